// File: rtl/mul16s_acc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mul16s_acc_pipe
// Description : Group accumulator for the signed approximate-multiplier
//               product stream. Sums each in_last-terminated group of beats
//               into a saturating ACC_W-bit accumulator, optionally removing
//               the constant multiplier offset, and presents one result per
//               group through a single-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module mul16s_acc_pipe #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16,
  parameter int BIAS   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              cfg_bias_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  // IDLE: no partial group open; ACCUM: at least one beat of a group taken.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [ACC_W:0]   c_bias     = (ACC_W+1)'(BIAS);
  localparam logic [ACC_W:0]   c_no_bias  = '0;
  localparam logic [ACC_W-1:0] c_acc_max  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered state
  state_t             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               sat_q,       sat_d;
  logic               bias_q,      bias_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q,   out_acc_d;
  logic               out_sat_q,   out_sat_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  // Datapath wires
  logic               w_accept;
  logic               w_consume;
  logic               w_first;
  logic               w_bias_use;
  logic [ACC_W:0]     w_term;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_clamped;
  logic [CNT_W-1:0]   w_count_inc;

  // The only stall is a full output register that is not being drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  // One-beat arithmetic in ACC_W+1 bits so overflow shows as a sign mismatch
  // between the top two bits; the bias choice is frozen on the first beat.
  always_comb begin
    w_first     = (state_q == ST_IDLE);
    w_bias_use  = w_first ? cfg_bias_en : bias_q;
    w_term      = {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod}
                  - (w_bias_use ? c_bias : c_no_bias);
    w_sum       = {acc_q[ACC_W-1], acc_q} + w_term;
    w_ovf       = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (!w_ovf) begin
      w_clamped = w_sum[ACC_W-1:0];
    end else if (w_sum[ACC_W]) begin
      w_clamped = c_acc_min;
    end else begin
      w_clamped = c_acc_max;
    end
    w_count_inc = (count_q == c_cnt_max) ? count_q : (count_q + c_cnt_one);
  end

  // Next-state: a consumed result frees the output register, and a last beat
  // accepted in the same cycle refills it so results can stream every cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_d       = sat_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    if (w_consume) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      if (w_first) begin
        bias_d = cfg_bias_en;
      end
      if (in_last) begin
        out_valid_d = 1'b1;
        out_acc_d   = w_clamped;
        out_sat_d   = sat_q | w_ovf;
        out_count_d = w_count_inc;
        acc_d       = '0;
        count_d     = '0;
        sat_d       = 1'b0;
        state_d     = ST_IDLE;
      end else begin
        acc_d       = w_clamped;
        count_d     = w_count_inc;
        sat_d       = sat_q | w_ovf;
        state_d     = ST_ACCUM;
      end
    end
  end

  // State and output registers with synchronous reset that drops any partial group.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      bias_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul16s_acc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul16s_acc_pipe
// Description : Directed and randomized bench for mul16s_acc_pipe with a
//               group-level arithmetic reference model and result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul16s_acc_pipe;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 16;
  localparam int BIAS   = 4;

  localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W-1));
  localparam int     CMAX = (1 << CNT_W) - 1;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              cfg_bias_en;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_sat;
  logic [CNT_W-1:0]  out_count;

  mul16s_acc_pipe #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .BIAS(BIAS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_last    (in_last),
    .cfg_bias_en(cfg_bias_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_sat    (out_sat),
    .out_count  (out_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: group sum with plain integer math and clamping.
  typedef struct {
    longint acc;
    bit     sat;
    int     cnt;
  } res_t;

  res_t   exp_q[$];
  bit     m_open = 1'b0;
  bit     m_bias = 1'b0;
  longint m_acc  = 0;
  bit     m_sat  = 1'b0;
  int     m_cnt  = 0;

  function automatic void model_reset();
    m_open = 1'b0; m_bias = 1'b0; m_acc = 0; m_sat = 1'b0; m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_push(input logic signed [31:0] p, input bit last,
                                     input bit ben);
    longint t;
    res_t   r;
    if (!m_open) m_bias = ben;
    t = p;
    if (m_bias) t = t - BIAS;
    m_acc = m_acc + t;
    if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1'b1; end
    if (m_acc < MINV) begin m_acc = MINV; m_sat = 1'b1; end
    if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (last) begin
      r.acc = m_acc; r.sat = m_sat; r.cnt = m_cnt;
      exp_q.push_back(r);
      m_open = 1'b0; m_acc = 0; m_sat = 1'b0; m_cnt = 0;
    end else begin
      m_open = 1'b1;
    end
  endfunction

  // Scoreboard: handshake rule, output hold under backpressure, result order.
  bit               hold_prev = 1'b0;
  logic [ACC_W-1:0] p_acc;
  logic             p_sat;
  logic [CNT_W-1:0] p_cnt;
  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_acc",   $signed(out_acc), $signed(p_acc));
        chk("hold_sat",   out_sat, p_sat);
        chk("hold_count", out_count, p_cnt);
      end
      if (out_valid && out_ready) begin
        chk("result_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb_acc",   $signed(out_acc), e.acc);
          chk("sb_sat",   out_sat, e.sat);
          chk("sb_count", out_count, e.cnt);
        end
      end
      hold_prev = out_valid && !out_ready;
      p_acc = out_acc; p_sat = out_sat; p_cnt = out_count;
    end
  end

  // Present one beat until accepted (bounded), starting just after a rising edge.
  task automatic send_beat(input logic signed [31:0] prod, input bit last, input bit ben);
    bit accepted;
    accepted    = 1'b0;
    in_valid    = 1'b1;
    in_prod     = prod;
    in_last     = last;
    cfg_bias_en = ben;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) != 0);
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) begin
        model_push(prod, last, ben);
        accepted = 1'b1;
      end
      @(posedge clock); #1;
      if (!accepted && rnd_ready) out_ready = ($urandom_range(0, 1) != 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("beat_accepted", accepted, 1);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) != 0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    cfg_bias_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc",   $signed(out_acc), 0);
    chk("rst_out_sat",   out_sat, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_ready",  in_ready, 1);
    reset = 1'b0;
    idle_cycle();

    // Basic group, bias off.
    send_beat(100, 0, 0); send_beat(-50, 0, 0); send_beat(30, 1, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_acc",   $signed(out_acc), 80);
    chk("t1_count", out_count, 3);
    chk("t1_sat",   out_sat, 0);
    idle_cycle();
    chk("t1_valid_drop", out_valid, 0);

    // Bias on, then bias toggled after the first beat.
    send_beat(104, 0, 1); send_beat(4, 0, 1); send_beat(-96, 1, 1);
    chk("t2_acc",   $signed(out_acc), 0);
    chk("t2_count", out_count, 3);
    idle_cycle();
    send_beat(104, 0, 1); send_beat(4, 0, 0); send_beat(-96, 1, 0);
    chk("t2b_acc",   $signed(out_acc), 0);
    chk("t2b_count", out_count, 3);
    chk("t2b_sat",   out_sat, 0);
    idle_cycle();

    // Saturation boundary.
    repeat (255) send_beat(32'sh7fffffff, 0, 0);
    send_beat(32'sh7fffffff, 1, 0);
    chk("t3a_acc", $signed(out_acc), 64'sd549755813632);
    chk("t3a_sat", out_sat, 0);
    chk("t3a_count", out_count, 256);
    repeat (256) send_beat(32'sh7fffffff, 0, 0);
    send_beat(32'sh7fffffff, 1, 0);
    chk("t3b_acc", $signed(out_acc), 64'sd549755813887);
    chk("t3b_sat", out_sat, 1);
    send_beat(5, 1, 0);
    chk("t3c_acc", $signed(out_acc), 5);
    chk("t3c_sat", out_sat, 0);
    idle_cycle();

    // Backpressure: result held, presented beat refused, then swap in one cycle.
    out_ready = 1'b0;
    send_beat(9, 1, 0);
    in_valid = 1'b1; in_prod = 32'd7; in_last = 1'b1; cfg_bias_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_held_valid",   out_valid, 1);
      chk("t4_held_acc",     $signed(out_acc), 9);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("t4_in_ready_high", in_ready, 1);
    if (in_ready) model_push(32'sd7, 1'b1, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_valid", out_valid, 1);
    chk("t4_acc",   $signed(out_acc), 7);
    chk("t4_count", out_count, 1);
    idle_cycle();

    // Back-to-back single-beat groups.
    send_beat(1, 1, 0);
    chk("t5_v1", out_valid, 1); chk("t5_a1", $signed(out_acc), 1);
    send_beat(2, 1, 0);
    chk("t5_v2", out_valid, 1); chk("t5_a2", $signed(out_acc), 2);
    send_beat(3, 1, 0);
    chk("t5_v3", out_valid, 1); chk("t5_a3", $signed(out_acc), 3);
    idle_cycle();

    // Reset in the middle of a group discards it.
    send_beat(10, 0, 0); send_beat(20, 0, 0);
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t6_no_output", out_valid, 0);
    idle_cycle();
    chk("t6_still_none", out_valid, 0);
    send_beat(5, 1, 0);
    chk("t6_acc",   $signed(out_acc), 5);
    chk("t6_count", out_count, 1);
    idle_cycle();

    // Randomized traffic with random downstream backpressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] p;
      if ($urandom_range(0, 3) == 0)
        p = ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
      else
        p = $urandom;
      send_beat(p, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) != 0));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    send_beat(0, 1, 0);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) idle_cycle();
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul16s_acc_pipe.md
Name: mul16s_acc_pipe

Overview:
- Downstream accumulation stage for the 16x16 signed approximate multiplier used in the PE datapath.
- Consumes a stream of signed 32-bit products over a valid/ready handshake and sums each group of beats into a saturating ACC_W-bit accumulator. A group is terminated by in_last.
- Optionally removes the constant +4 offset that the approximate multiplier inserts in product bits [3:0].
- Emits one result per group through a single-entry output register with valid/ready.

Parameters:
- PROD_W, 32, product width (signed)
- ACC_W, 40, accumulator/result width (signed); must be > PROD_W
- CNT_W, 16, beat-counter width
- BIAS, 4, constant subtracted per beat when cfg_bias_en=1

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_prod  in  PROD_W  signed product
- in_last  in  1  beat closes the current group
- cfg_bias_en  in  1  subtract BIAS from each beat; sampled on the first beat of a group
- out_valid  out  1  result held in output register
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  signed group sum
- out_sat  out  1  saturation occurred in this group
- out_count  out  CNT_W  beats in the group (saturates at 2^CNT_W-1)

Behaviour:
- Reset (synchronous, active-high, overrides everything): acc=0, count=0, sat=0, bias_q=0, out_valid=0, out_acc=0, out_sat=0, out_count=0, state=IDLE. Asserting reset mid-group discards the partial group with no output.
- Handshakes:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational). There is no other stall.
  - Result consumed when out_valid && out_ready.
- States:
  - IDLE (no partial group). Accepted beat: bias_q <= cfg_bias_en, then state ACCUM, or directly a result if in_last.
  - ACCUM (partial group open). Beats accumulate; cfg_bias_en is ignored.
  - An accepted beat with in_last loads the output register and returns the state to IDLE.
- Per-beat arithmetic, in ACC_W+1 bits:
  - term = sext(in_prod) - (bias ? BIAS : 0), where bias is cfg_bias_en on the first beat and bias_q on later beats.
  - sum = acc + term.
  - If sum exceeds the signed ACC_W range, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set sat (sticky for the group).
  - count increments, holding at its max.
- Accepted last beat:
  - Next cycle: out_valid=1, out_acc=clamped sum, out_sat=sat|new overflow, out_count=count+1 (saturating).
  - acc, count and sat clear to 0.
  - Latency from last-beat acceptance to out_valid is 1 cycle.
  - Single-beat groups are legal: in_last on the first beat.
- Output hold:
  - out_* stay stable while out_valid && !out_ready.
  - out_valid drops the cycle after consumption unless a new last beat is accepted in the same cycle.
  - If a new last beat is accepted in the same cycle, out_valid stays 1 and out_* take the new result (back-to-back throughput of 1 result/cycle).
- Simultaneous output consumption and beat acceptance is legal. The beat goes to the current or new group per the state rules, with no beat lost or duplicated.
- A beat cannot be accepted while out_valid && !out_ready; the upstream multiplier stalls.
- in_prod, in_last and cfg_bias_en are ignored when in_valid=0.

Test Plan:
- Bias off, beats 100, -50, 30(last), out_ready=1 -> one cycle later out_valid=1, out_acc=80, out_count=3, out_sat=0; then out_valid=0.
- Bias on, beats 104, 4, -96(last) -> out_acc=0, out_count=3. Toggle cfg_bias_en to 0 on beat 2 -> result unchanged (bias sampled on the first beat).
- Saturation, ACC_W=40, bias off:
  - 256 beats of 2147483647 -> out_acc=549755813632, out_sat=0.
  - 257 beats -> out_acc=549755813887, out_sat=1.
  - Next group 5(last) -> out_acc=5, out_sat=0.
- Backpressure:
  - Result held with out_ready=0 for 4 cycles -> in_ready=0, out_* stable, presented beats not accepted.
  - Then out_ready=1 with beat 7(last) -> same cycle consumes the old result, next cycle out_acc=7, out_count=1.
- Back-to-back single-beat groups 1, 2, 3 (all last), out_ready=1 -> out_acc 1, 2, 3 on consecutive cycles, out_valid continuously 1.
- Reset pulse after beats 10, 20 with no last -> no output. Then beat 5(last) -> out_acc=5, out_count=1.
